// File: rtl/q_time_pkg.sv
// Shared timestamp types and the half-range modular "is in the past" compare
// used by the timestamp queue and the dispatcher lateness checks.
package q_time_pkg;

   localparam int Q_TS_W = 20;

   typedef logic [Q_TS_W-1:0] q_ts_t;

   localparam q_ts_t Q_TS_HALF = {1'b1, {(Q_TS_W-1){1'b0}}};

   // ts is past when t_cnt is strictly ahead of it by less than half the range.
   function automatic logic ts_is_past(input q_ts_t t_cnt, input q_ts_t ts);
      q_ts_t d;
      d = t_cnt - ts;
      return (d != '0) && (d < Q_TS_HALF);
   endfunction

endpackage

// File: rtl/q_time_wrap_cmp.sv
// Combinational wrap-safe compare: past=1 when ts lies strictly behind t_cnt
// within the half-range window of a W-bit free-running counter.
module q_time_wrap_cmp
   import q_time_pkg::*;
#(
   parameter int W = Q_TS_W
) (
   input  logic [W-1:0] t_cnt,
   input  logic [W-1:0] ts,
   output logic         past
);

   generate
      if (W == Q_TS_W) begin : g_pkg
         assign past = ts_is_past(t_cnt, ts);
      end else begin : g_generic
         logic [W-1:0] d;
         assign d    = t_cnt - ts;
         assign past = (d != '0) && !d[W-1];
      end
   endgenerate

endmodule

// File: rtl/q_time_sched.sv
// Issue-timestamp queue with absolute/relative writes, show-ahead head,
// wrap-safe lateness flag and sticky errors. Optional Q_TIME_BYPASS_EN
// lets a write on an empty queue flow straight through to a same-cycle read.
module q_time_sched
   import q_time_pkg::*;
#(
   parameter int DEPTH      = 32,
   parameter int DATA_WIDTH = 20,
   parameter int AF_THRESH  = DEPTH - 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic                         wr_rel,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         rd_en,
   input  logic [DATA_WIDTH-1:0]        t_cnt,
   input  logic                         clr_err,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         data_valid,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         late,
   output logic                         ovf_err,
   output logic                         udf_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Handshake: data_valid acts as "valid" for the head and rd_en as "ready";
   // a pop happens only on rd_en && data_valid. !full is the producer's
   // ready; wr_en while full is dropped unless a pop frees a slot that edge.

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] last_ts;
   logic [DATA_WIDTH-1:0] wr_value;
   logic [CW-1:0]         count_nxt;
   logic                  bypass, wr_acc, rd_acc, ovf_set, udf_set, head_past;

   always_comb begin
      wr_value = wr_rel ? (last_ts + data_in) : data_in;
`ifdef Q_TIME_BYPASS_EN
      bypass = empty && wr_en && rd_en;
`else
      bypass = 1'b0;
`endif
      wr_acc  = wr_en && (!full || rd_en) && !bypass;
      rd_acc  = rd_en && !empty;
      ovf_set = wr_en && full && !rd_en;
      udf_set = rd_en && empty && !bypass;

      count_nxt = count;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Storage is never reset; empty/count gate everything read from it.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_value;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
         last_ts     <= '0;
         ovf_err     <= 1'b0;
         udf_err     <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         if (wr_acc || bypass) last_ts <= wr_value;
         count       <= count_nxt;
         full        <= (count_nxt == CW'(DEPTH));
         empty       <= (count_nxt == '0);
         almost_full <= (count_nxt >= CW'(AF_THRESH));
         // A new error event outranks a coincident clear.
         if (ovf_set)      ovf_err <= 1'b1;
         else if (clr_err) ovf_err <= 1'b0;
         if (udf_set)      udf_err <= 1'b1;
         else if (clr_err) udf_err <= 1'b0;
      end
   end

   always_comb begin
      data_out   = '0;
      data_valid = 1'b0;
      if (bypass) begin
         data_out   = wr_value;
         data_valid = 1'b1;
      end else if (!empty) begin
         data_out   = mem[rd_ptr];
         data_valid = 1'b1;
      end
   end

   q_time_wrap_cmp #(.W(DATA_WIDTH)) u_late_cmp (
      .t_cnt (t_cnt),
      .ts    (data_out),
      .past  (head_past)
   );

   assign late = data_valid && head_past;

endmodule

// File: doc/q_time_sched.md
Name: q_time_sched

Overview:
Parametrised successor to the single-mode timestamp FIFO in the quantum control path. It buffers issue timestamps produced by the quantum decoder and presents the head entry to instruction combination. It adds a relative-timing write mode and modulo wrap-safe lateness detection against the free-running t_cnt. It also provides occupancy, almost-full and sticky overflow/underflow error reporting.

Parameters:
DEPTH, 32, number of entries; power of two, >= 2
DATA_WIDTH, 20, timestamp width; matches t_cnt width
AF_THRESH, DEPTH-2, count at or above which almost_full asserts; 1..DEPTH

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  push a timestamp
wr_rel  in  1  1: data_in is a delta added to the last accepted timestamp; 0: data_in is absolute
data_in  in  DATA_WIDTH  timestamp or delta
rd_en  in  1  pop the head entry
t_cnt  in  DATA_WIDTH  current time counter, free-running, wraps
clr_err  in  1  clear sticky error flags
data_out  out  DATA_WIDTH  head timestamp (show-ahead)
data_valid  out  1  data_out holds a valid entry
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
count  out  $clog2(DEPTH+1)  occupancy
late  out  1  head timestamp is already in the past relative to t_cnt
ovf_err  out  1  sticky: write dropped while full
udf_err  out  1  sticky: read while empty

Behaviour:
- Reset (clk edge with reset=1): pointers=0, count=0, last_ts=0, ovf_err=udf_err=0. Outputs: empty=1, full=0, almost_full=0, data_valid=0, late=0, data_out=0. Reset mid-operation discards all entries; storage contents need not be cleared.
- Write value: wr_rel=0 gives value=data_in. wr_rel=1 gives value=(last_ts+data_in) mod 2^DATA_WIDTH, with the carry discarded. An accepted write sets last_ts <= value.
- Accepted write: wr_en && (!full || rd_en). The value is stored at wr_ptr and wr_ptr advances, wrapping at DEPTH. It is visible on data_out one cycle later if the queue was empty.
- Dropped write: wr_en && full && !rd_en. Storage, pointers and last_ts are unchanged; ovf_err <= 1.
- Accepted read: rd_en && !empty. rd_ptr advances; the next entry appears on data_out the following cycle.
- Read while empty: rd_en && empty is ignored and sets udf_err <= 1. This includes a simultaneous wr_en; that write is still accepted (see the Optional Feature for the exception).
- Simultaneous accepted read and write: count is unchanged. At full, both are accepted.
- count, full, empty and almost_full are registered and updated in the same edge as the pointers.
- data_out = mem[rd_ptr] when !empty, else 0. data_valid = !empty.
- late (combinational): data_valid && d != 0 && d[DATA_WIDTH-1] == 0, where d = (t_cnt - data_out) mod 2^DATA_WIDTH. The half-range window handles t_cnt wrap-around. late does not auto-pop.
- clr_err clears both sticky flags. If clr_err coincides with a new error event, the flag is set (the error wins).
- No state machine beyond the pointer/count logic; single-cycle throughput of 1 write and 1 read per clock.

Optional Feature:
- Q_TIME_BYPASS_EN defined: when empty && wr_en && rd_en, the write value bypasses storage.
  - In that cycle data_out = value and data_valid = 1, both combinational.
  - The value is consumed: count stays 0, pointers do not move, last_ts updates, udf_err is not set.
  - late evaluates on the bypassed value.
- Q_TIME_BYPASS_EN undefined: the baseline empty-read behaviour applies.

Decomposition:
- Package q_time_pkg:
  - typedef q_ts_t (logic [DATA_WIDTH-1:0], default width 20)
  - function ts_is_past(t_cnt, ts) implementing the half-range modular compare
  - localparam Q_TS_HALF
- Sub-module q_time_wrap_cmp: purely combinational modular compare, reused by dispatcher lateness checks.
- Storage is a plain register array; no vendor RAM.

Test Plan:
- Reset, then write abs 100, 200, 300 -> count=3; data_out=100 next cycle; three reads yield 100, 200, 300; then empty=1, data_valid=0.
- Abs write 1000, then rel writes 5 and 7 -> stored 1000, 1005, 1012. With DATA_WIDTH=20, abs 0xFFFFE followed by rel 4 -> stored 0x00002 (wrap).
- Fill to DEPTH=32 -> full=1, almost_full at count 30. 33rd write without read -> dropped, ovf_err=1, count=32. Write+read at full -> both accepted, count=32. clr_err together with a dropped write -> ovf_err stays 1.
- Read while empty -> udf_err=1, count=0. Write+read while empty -> count=1 and udf_err=1 (macro undefined); count=0, data_out=value, data_valid=1, udf_err=0 (macro defined).
- Head=0x00010: t_cnt=0x0000F -> late=0; t_cnt=0x00011 -> late=1. Head=0xFFFF0 with t_cnt=0x00005 -> late=1; head=0x00005 with t_cnt=0xFFFF0 -> late=0.
- Assert reset with 10 entries queued -> next cycle count=0, empty=1, errors=0, last_ts=0. A following rel write of 3 stores 3.
